genius_ctrl: RTL and testbench
==============================

Name: genius_ctrl

Overview:
Round sequencer for the Genius (Simon) game. It addresses the 4-bit sequence table and plays the first N steps of the pattern on the LEDs. It then checks the player's button presses against the same table and advances N until a win or a loss. It sits between the sequence table (combinational, one-hot data per address) and the board LEDs and buttons.

Parameters:
SHOW_CYCLES, 25000000, clock cycles each step's LED stays lit during playback (>=1)
GAP_CYCLES, 12500000, dark cycles after each playback step and before each new round (>=1)
TIMEOUT_CYCLES, 250000000, maximum idle cycles allowed between player presses in WAIT_IN (>=1)
MAX_ROUND, 16, round count that wins the game (1..16)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock, asynchronous assert, active-low
start  input  1  one-cycle pulse; starts or restarts the game from IDLE, WIN or LOSE
btn_pulse  input  4  one-cycle press pulses, already synchronised and debounced; bit i = colour i
seq_addr  output  4  address to the sequence table
seq_data  input  4  one-hot step colour returned combinationally for seq_addr
led  output  4  LED drive, registered
round  output  5  current round (number of steps in play), registered
busy  output  1  high in every state except IDLE, WIN and LOSE
win  output  1  high while in WIN
lose  output  1  high while in LOSE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; idx=0; timer=0.
  - seq_addr=0, led=0, round=0, busy=0, win=0, lose=0.
  - Reset mid-game aborts immediately.
- Registered outputs: all outputs are registered. seq_addr is driven from the registered idx, so seq_data is valid in the same cycle.
- IDLE:
  - led=0.
  - start=1 -> round=1, idx=0, timer=0, go to SHOW.
- SHOW:
  - led=seq_data. It holds exactly SHOW_CYCLES cycles, starting the cycle after the entering edge.
  - Timer expiry -> led=0, go to GAP.
- GAP:
  - led=0 for GAP_CYCLES cycles.
  - On expiry: idx+1 < round -> idx++, go to SHOW.
  - Otherwise -> idx=0, timer=0, go to WAIT_IN.
- WAIT_IN:
  - led=0, seq_addr=idx. Timer counts every cycle.
  - btn_pulse==0: no action.
  - btn_pulse==seq_data (exact match) -> timer=0, idx++.
    - If idx+1==round and round==MAX_ROUND -> WIN.
    - Else if idx+1==round -> round++, idx=0, go to PAUSE.
    - Else stay in WAIT_IN.
  - btn_pulse nonzero and mismatched (wrong colour or multi-hot) -> LOSE.
  - timer reaches TIMEOUT_CYCLES-1 with no press -> LOSE. A press in that same cycle takes priority.
- PAUSE: led=0 for GAP_CYCLES cycles, then go to SHOW with idx=0.
- WIN: win=1, led=4'b1111.
- LOSE: lose=1, led=seq_data at the failing idx, so the correct colour is shown. round holds its final value.
- Leaving WIN or LOSE:
  - start=1 -> clear win/lose, round=1, idx=0, go to SHOW.
  - btn_pulse is ignored in these states.
- start is ignored in SHOW, GAP, WAIT_IN and PAUSE, including when it coincides with a press.
- btn_pulse is ignored outside WAIT_IN.
- Width rules:
  - idx is 4 bits; round is 5 bits (1..16, never wraps).
  - Comparisons use idx+1 computed at 5 bits.
  - Timers are sized by $clog2 of the largest parameter.

Test Plan:
Common setup: SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=20, MAX_ROUND=16; table starts addr0=0001, addr1=0100, addr2=0001.
1. Reset then start pulse -> busy=1, round=1; led=0001 for exactly 4 cycles, then 0 for 2; WAIT_IN with seq_addr=0.
2. Round 1: press 0001 -> PAUSE 2 cycles, round=2. Playback led = 0001(4), 0(2), 0100(4), 0(2), then WAIT_IN.
3. Round 2: press 0001 then 0010 -> lose=1, busy=0, led=0100, round=2. A later start pulse -> lose=0, round=1, playback restarts.
4. In WAIT_IN, no press for 20 cycles -> lose=1. Pressing on cycle 19 instead -> accepted, timer cleared.
5. Drive correct presses through all 16 rounds -> after the 16th correct press: win=1, led=1111, round=16. Then btn_pulse has no effect; start restarts at round 1.
6. Assert rst_n=0 mid-SHOW -> all outputs 0 asynchronously, state IDLE. A start pulse asserted together with a correct press in WAIT_IN -> press accepted, start ignored.

Source files
------------

// File: rtl/genius_ctrl.sv
// Round sequencer for a Simon-style game: plays the first `round` steps of the
// sequence table on the LEDs, then checks the player's presses against it.
module genius_ctrl #(
  parameter int SHOW_CYCLES    = 25000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 250000000,
  parameter int MAX_ROUND      = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] btn_pulse,
  output logic [3:0] seq_addr,
  input  logic [3:0] seq_data,
  output logic [3:0] led,
  output logic [4:0] round,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int MAX_SG = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int MAX_P  = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
  localparam int TW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    MAX_R     = 5'(MAX_ROUND);

  typedef enum logic [2:0] {IDLE, SHOW, GAP, WAIT_IN, PAUSE, WIN, LOSE} state_t;

  state_t        state, state_nx;
  logic [3:0]    idx, idx_nx;
  logic [TW-1:0] timer, timer_nx;
  logic [4:0]    round_nx;
  logic [3:0]    led_nx;
  logic [4:0]    idx_inc;

  assign seq_addr = idx;
  assign idx_inc  = {1'b0, idx} + 5'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      timer <= '0;
      round <= '0;
      led   <= '0;
      busy  <= 1'b0;
      win   <= 1'b0;
      lose  <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      timer <= timer_nx;
      round <= round_nx;
      led   <= led_nx;
      busy  <= !(state_nx inside {IDLE, WIN, LOSE});
      win   <= (state_nx == WIN);
      lose  <= (state_nx == LOSE);
    end
  end

  // idx is advanced when a step's lit time ends rather than when its gap ends,
  // so the table already presents the next colour and the LED lights on the
  // very edge that enters SHOW. idx is also parked at 0 in IDLE/WIN/LOSE/PAUSE.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    timer_nx = timer;
    round_nx = round;
    led_nx   = led;
    case (state)
      IDLE, WIN, LOSE: begin
        if (state == IDLE) led_nx = '0;
        if (state == WIN)  led_nx = 4'hf;
        if (start) begin
          state_nx = SHOW;
          round_nx = 5'd1;
          idx_nx   = '0;
          timer_nx = '0;
          led_nx   = seq_data;
        end
      end
      SHOW: begin
        led_nx   = seq_data;
        timer_nx = timer + TW'(1);
        if (timer == SHOW_LAST) begin
          state_nx = GAP;
          led_nx   = '0;
          timer_nx = '0;
          idx_nx   = (idx_inc < round) ? idx + 4'd1 : 4'd0;
        end
      end
      GAP: begin
        led_nx   = '0;
        timer_nx = timer + TW'(1);
        if (timer == GAP_LAST) begin
          timer_nx = '0;
          if (idx != 4'd0) begin
            state_nx = SHOW;
            led_nx   = seq_data;
          end else begin
            state_nx = WAIT_IN;
          end
        end
      end
      WAIT_IN: begin
        led_nx   = '0;
        timer_nx = timer + TW'(1);
        if (btn_pulse != 4'd0) begin
          timer_nx = '0;
          if (btn_pulse == seq_data) begin
            if (idx_inc == round && round == MAX_R) begin
              state_nx = WIN;
              led_nx   = 4'hf;
              idx_nx   = '0;
            end else if (idx_inc == round) begin
              state_nx = PAUSE;
              round_nx = round + 5'd1;
              idx_nx   = '0;
            end else begin
              idx_nx = idx + 4'd1;
            end
          end else begin
            state_nx = LOSE;
            led_nx   = seq_data;
            idx_nx   = '0;
          end
        end else if (timer == TOUT_LAST) begin
          state_nx = LOSE;
          led_nx   = seq_data;
          idx_nx   = '0;
          timer_nx = '0;
        end
      end
      PAUSE: begin
        led_nx   = '0;
        timer_nx = timer + TW'(1);
        if (timer == GAP_LAST) begin
          state_nx = SHOW;
          timer_nx = '0;
          led_nx   = seq_data;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_genius_ctrl.sv
// Scoreboarded bench for genius_ctrl: the game timeline is generated from the
// rules into an expectation queue, and a negedge monitor checks every cycle.
`timescale 1ns/1ps
module tb_genius_ctrl;

  localparam int S  = 4;
  localparam int G  = 2;
  localparam int T  = 20;
  localparam int MR = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn_pulse = 4'd0;
  logic [3:0] seq_addr, seq_data, led;
  logic [4:0] round;
  logic       busy, win, lose;
  logic [3:0] tab [16];

  assign seq_data = tab[seq_addr];

  genius_ctrl #(
    .SHOW_CYCLES(S), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T), .MAX_ROUND(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .btn_pulse(btn_pulse),
    .seq_addr(seq_addr), .seq_data(seq_data), .led(led), .round(round),
    .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] led;
    logic [4:0] round;
    logic       busy;
    logic       win;
    logic       lose;
    logic       chk_addr;
    logic [3:0] addr;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    tests = 0;
  int    failed = 0;
  exp_t  m_e;
  string m_tag;

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e   = exp_q.pop_front();
      m_tag = tag_q.pop_front();
      tests++;
      if (led !== m_e.led || round !== m_e.round || busy !== m_e.busy ||
          win !== m_e.win || lose !== m_e.lose ||
          (m_e.chk_addr && seq_addr !== m_e.addr)) begin
        failed++;
        $display("FAIL %s @%0t: got led=%b round=%0d busy=%b win=%b lose=%b addr=%0d, expected led=%b round=%0d busy=%b win=%b lose=%b addr=%0d (addr checked=%b)",
                 m_tag, $time, led, round, busy, win, lose, seq_addr,
                 m_e.led, m_e.round, m_e.busy, m_e.win, m_e.lose, m_e.addr, m_e.chk_addr);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t mk(logic [3:0] l, logic [4:0] r, logic b, logic w,
                              logic ls, logic ca, logic [3:0] a);
    exp_t e;
    e.led = l; e.round = r; e.busy = b; e.win = w; e.lose = ls;
    e.chk_addr = ca; e.addr = a;
    return e;
  endfunction

  function automatic exp_t e_busy(logic [3:0] l, int r, logic ca, int a);
    return mk(l, 5'(r), 1'b1, 1'b0, 1'b0, ca, 4'(a));
  endfunction

  function automatic exp_t e_lose(logic [3:0] l, int r);
    return mk(l, 5'(r), 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
  endfunction

  function automatic exp_t e_win();
    return mk(4'hf, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
  endfunction

  function automatic exp_t e_zero();
    return mk(4'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
  endfunction

  function automatic logic [3:0] nb();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic ns();
    return ($urandom_range(0, 5) == 0);
  endfunction

  function automatic logic [3:0] bad(logic [3:0] c);
    logic [3:0] v;
    do v = 4'($urandom_range(1, 15)); while (v == c);
    return v;
  endfunction

  // Drive inputs for the next edge and queue the outputs expected after it.
  task automatic tick(input logic st, input logic [3:0] b, input exp_t e, input string tag);
    start = st;
    btn_pulse = b;
    @(posedge clk);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    start = 1'b0;
    btn_pulse = 4'd0;
  endtask

  task automatic playback(input int r, input logic first_start);
    for (int k = 0; k < r; k++) begin
      for (int c = 0; c < S; c++) begin
        if (first_start && k == 0 && c == 0)
          tick(1'b1, nb(), e_busy(tab[k], r, 1'b0, 0), "start_show");
        else
          tick(ns(), nb(), e_busy(tab[k], r, 1'b0, 0), "show");
      end
      for (int c = 0; c < G; c++)
        tick(ns(), nb(), e_busy(4'd0, r, 1'b0, 0), "gap");
    end
    tick(ns(), nb(), e_busy(4'd0, r, 1'b1, 0), "wait_entry");
  endtask

  task automatic wait_idle(input int n, input int j, input int r);
    for (int i = 0; i < n; i++)
      tick(ns(), 4'd0, e_busy(4'd0, r, 1'b1, j), "wait_idle");
  endtask

  task automatic press_ok(input int j, input int r, input logic st);
    if (j + 1 < r) begin
      tick(st, tab[j], e_busy(4'd0, r, 1'b1, j + 1), "press_ok");
    end else if (r == MR) begin
      tick(st, tab[j], e_win(), "press_win");
    end else begin
      tick(st, tab[j], e_busy(4'd0, r + 1, 1'b0, 0), "press_round");
      for (int i = 0; i < G - 1; i++)
        tick(ns(), nb(), e_busy(4'd0, r + 1, 1'b0, 0), "pause");
    end
  endtask

  task automatic press_bad(input int j, input int r, input logic [3:0] b);
    tick(ns(), b, e_lose(tab[j], r), "press_bad");
  endtask

  task automatic hold_lose(input int n, input int j, input int r);
    for (int i = 0; i < n; i++)
      tick(1'b0, nb(), e_lose(tab[j], r), "hold_lose");
  endtask

  task automatic hold_win(input int n);
    for (int i = 0; i < n; i++)
      tick(1'b0, nb(), e_win(), "hold_win");
  endtask

  task automatic timeout(input int j, input int r);
    wait_idle(T - 1, j, r);
    tick(ns(), 4'd0, e_lose(tab[j], r), "timeout");
  endtask

  task automatic round_play(input int r, input logic fs, input int maxd);
    playback(r, fs);
    for (int j = 0; j < r; j++) begin
      wait_idle($urandom_range(0, maxd), j, r);
      press_ok(j, r, ns());
    end
  endtask

  initial begin
    tab[0] = 4'b0001;
    tab[1] = 4'b0100;
    tab[2] = 4'b0001;
    for (int i = 3; i < 16; i++) tab[i] = 4'b0001 << $urandom_range(0, 3);

    // Reset and idle
    tick(1'b0, 4'd0, e_zero(), "reset");
    tick(1'b0, 4'd0, e_zero(), "reset");
    tests++;
    if (led !== 4'd0 || round !== 5'd0 || busy !== 1'b0 || win !== 1'b0 ||
        lose !== 1'b0 || seq_addr !== 4'd0) begin
      failed++;
      $display("FAIL direct_reset @%0t: led=%b round=%0d busy=%b win=%b lose=%b addr=%0d",
               $time, led, round, busy, win, lose, seq_addr);
    end
    rst_n = 1'b1;
    tick(1'b0, nb(), e_zero(), "idle");
    tick(1'b0, nb(), e_zero(), "idle");

    // First round, second round, then a wrong colour and restart
    round_play(1, 1'b1, 3);
    playback(2, 1'b0);
    wait_idle(2, 0, 2);
    press_ok(0, 2, 1'b0);
    wait_idle(1, 1, 2);
    press_bad(1, 2, 4'b0010);
    tests++;
    if (lose !== 1'b1 || busy !== 1'b0 || led !== 4'b0100 || round !== 5'd2) begin
      failed++;
      $display("FAIL direct_lose @%0t: lose=%b busy=%b led=%b round=%0d",
               $time, lose, busy, led, round);
    end
    hold_lose(3, 1, 2);

    // Presses on the last allowed cycle, then a timeout
    round_play(1, 1'b1, 2);
    playback(2, 1'b0);
    wait_idle(T - 1, 0, 2);
    press_ok(0, 2, 1'b1);
    wait_idle(T - 1, 1, 2);
    press_ok(1, 2, 1'b0);
    playback(3, 1'b0);
    wait_idle(1, 0, 3);
    press_ok(0, 3, 1'b0);
    timeout(1, 3);
    tests++;
    if (lose !== 1'b1 || round !== 5'd3) begin
      failed++;
      $display("FAIL direct_timeout @%0t: lose=%b round=%0d", $time, lose, round);
    end
    hold_lose(2, 1, 3);

    // Multi-hot press containing the right colour still loses
    round_play(1, 1'b1, 2);
    playback(2, 1'b0);
    wait_idle(1, 0, 2);
    press_bad(0, 2, 4'b0011);
    hold_lose(2, 0, 2);

    // Full game to a win, presses ignored afterwards, restart
    for (int r = 1; r <= MR; r++) round_play(r, (r == 1), 3);
    hold_win(4);
    tests++;
    if (win !== 1'b1 || led !== 4'hf || round !== 5'd16 || busy !== 1'b0) begin
      failed++;
      $display("FAIL direct_win @%0t: win=%b led=%b round=%0d busy=%b",
               $time, win, led, round, busy);
    end
    round_play(1, 1'b1, 1);

    // Asynchronous reset in the middle of SHOW
    tick(ns(), nb(), e_busy(tab[0], 2, 1'b0, 0), "show");
    tick(ns(), nb(), e_busy(tab[0], 2, 1'b0, 0), "show");
    @(posedge clk);
    exp_q.push_back(e_zero());
    tag_q.push_back("async_reset");
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (led !== 4'd0 || round !== 5'd0 || busy !== 1'b0 || seq_addr !== 4'd0) begin
      failed++;
      $display("FAIL direct_async_reset @%0t: led=%b round=%0d busy=%b addr=%0d",
               $time, led, round, busy, seq_addr);
    end
    tick(1'b0, 4'd0, e_zero(), "in_reset");
    rst_n = 1'b1;
    tick(1'b0, nb(), e_zero(), "idle_after_reset");

    // start coinciding with a correct press is ignored
    playback(1, 1'b1);
    wait_idle(2, 0, 1);
    press_ok(0, 1, 1'b1);
    playback(2, 1'b0);
    wait_idle(0, 0, 2);
    press_ok(0, 2, 1'b1);
    wait_idle(2, 1, 2);
    press_bad(1, 2, bad(tab[1]));
    hold_lose(2, 1, 2);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
